// File: rtl/shift_unit_arbiter_pkg.sv
// Shared types and constants for the shift unit arbiter: op codes, FSM states, port ids
// and the captured-command payload.
package shift_unit_arbiter_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned SHAMT_W = 5;
    localparam int unsigned OP_W    = 2;

    typedef enum logic [OP_W-1:0] {
        SHOP_SLL  = 2'b00,
        SHOP_SRL  = 2'b01,
        SHOP_SRA  = 2'b10,
        SHOP_PASS = 2'b11
    } shop_e;

    typedef enum logic {
        SH_IDLE = 1'b0,
        SH_EXEC = 1'b1
    } sh_state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        shop_e             op;
        logic              port;
    } sh_cmd_t;

    // Any amount bit above the shamt field pushes the shift out of range.
    function automatic logic out_of_range(input logic [DATA_W-1:0] b);
        return |b[DATA_W-1:SHAMT_W];
    endfunction

endpackage

// File: rtl/shift_unit_arbiter_if.sv
// Two-requester shift request / response bundle; the master side is the requesters,
// the slave side is the arbiter.
interface shift_unit_arbiter_if;
    import shift_unit_arbiter_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;

    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;

    logic              rsp0_valid;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp_data;
    logic              busy;

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp1_valid, rsp_data, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp1_valid, rsp_data, busy
    );

endinterface

// File: rtl/shift_unit_arbiter_barrel_shifter.sv
// Combinational 32-bit logarithmic barrel shifter; dir=1 shifts left, vacated bits
// take feedinbit.
module BarrelShifter
    import shift_unit_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0]  din,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               dir,
    input  logic               feedinbit,
    output logic [DATA_W-1:0]  dout_c
);

    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] fill;
    logic [DATA_W-1:0] ones;

    // One conditional power-of-two stage per shamt bit.
    always_comb begin
        ones = '1;
        fill = {DATA_W{feedinbit}};
        x    = din;
        for (int unsigned s = 0; s < SHAMT_W; s++) begin
            if (shamt[s]) begin
                if (dir) begin
                    x = (x << (1 << s)) | (fill & ~(ones << (1 << s)));
                end else begin
                    x = (x >> (1 << s)) | (fill & ~(ones >> (1 << s)));
                end
            end
        end
        dout_c = x;
    end

endmodule

// File: rtl/shift_unit_arbiter.sv
// Round-robin two-port sequencer sharing one BarrelShifter; 2-cycle latency, one op per 2 cycles.
// Optional macro SHIFT_ARITH_EN enables arithmetic right shift (op 10); otherwise op 10 acts as SRL.
module shift_unit_arbiter
    import shift_unit_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    shift_unit_arbiter_if.slave  bus
);

    sh_state_e         state_q, state_d;
    sh_cmd_t           cmd_q, cmd_d;
    logic              last_grant_q, last_grant_d;
    logic              rsp0_valid_q, rsp0_valid_d;
    logic              rsp1_valid_q, rsp1_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic              busy_q, busy_d;

    logic              ready0_c, ready1_c;
    logic              hs0_c, hs1_c, hs_c;
    logic              dir_c, feedin_c;
    logic [DATA_W-1:0] shift_out_c, result_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= SH_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            SH_IDLE: if (hs_c) state_d = SH_EXEC;
            SH_EXEC: state_d = SH_IDLE;
            default: state_d = SH_IDLE;
        endcase
    end

    // Arbitration, operand capture and response staging.
    always_comb begin
        ready0_c = 1'b0;
        ready1_c = 1'b0;
        if (state_q == SH_IDLE) begin
            ready0_c = bus.req0_valid && (!bus.req1_valid || (last_grant_q == PORT1));
            ready1_c = bus.req1_valid && (!bus.req0_valid || (last_grant_q == PORT0));
        end
        hs0_c = bus.req0_valid && ready0_c;
        hs1_c = bus.req1_valid && ready1_c;
        hs_c  = hs0_c || hs1_c;

        cmd_d        = cmd_q;
        last_grant_d = last_grant_q;
        if (hs0_c) begin
            cmd_d = '{a: bus.req0_a, b: bus.req0_b, op: shop_e'(bus.req0_op), port: PORT0};
            last_grant_d = PORT0;
        end else if (hs1_c) begin
            cmd_d = '{a: bus.req1_a, b: bus.req1_b, op: shop_e'(bus.req1_op), port: PORT1};
            last_grant_d = PORT1;
        end

        rsp0_valid_d = (state_q == SH_EXEC) && (cmd_q.port == PORT0);
        rsp1_valid_d = (state_q == SH_EXEC) && (cmd_q.port == PORT1);
        rsp_data_d   = (state_q == SH_EXEC) ? result_c : rsp_data_q;
        busy_d       = hs_c || (state_q == SH_EXEC);
    end

    // Shifter drive and out-of-range fix-up; out-of-range result is the fill bit replicated.
    always_comb begin
        dir_c    = (cmd_q.op == SHOP_SLL);
        feedin_c = 1'b0;
`ifdef SHIFT_ARITH_EN
        feedin_c = (cmd_q.op == SHOP_SRA) && cmd_q.a[DATA_W-1];
`endif
        result_c = shift_out_c;
        if (cmd_q.op == SHOP_PASS) begin
            result_c = cmd_q.a;
        end else if (out_of_range(cmd_q.b)) begin
            result_c = {DATA_W{feedin_c}};
        end
    end

    BarrelShifter u_shifter (
        .din       (cmd_q.a),
        .shamt     (cmd_q.b[SHAMT_W-1:0]),
        .dir       (dir_c),
        .feedinbit (feedin_c),
        .dout_c    (shift_out_c)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_q        <= '0;
            last_grant_q <= PORT1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp_data_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            cmd_q        <= cmd_d;
            last_grant_q <= last_grant_d;
            rsp0_valid_q <= rsp0_valid_d;
            rsp1_valid_q <= rsp1_valid_d;
            rsp_data_q   <= rsp_data_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req0_ready = ready0_c;
    assign bus.req1_ready = ready1_c;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Directed self-checking bench for shift_unit_arbiter with a response scoreboard.
module tb_shift_unit_arbiter;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

`ifdef SHIFT_ARITH_EN
    localparam logic [31:0] EXP_SRA_B40 = 32'hFFFF_FFFF;
    localparam logic [31:0] EXP_SRA_B4  = 32'hF800_0000;
`else
    localparam logic [31:0] EXP_SRA_B40 = 32'h0000_0000;
    localparam logic [31:0] EXP_SRA_B4  = 32'h0800_0000;
`endif

    typedef struct {
        logic        port;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t mon_e;

    logic [31:0] pa [2];
    logic [31:0] pb [2];
    logic [1:0]  pop [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    shift_unit_arbiter_if bus ();

    shift_unit_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Logical-shift reference used for generated round-robin traffic.
    function automatic logic [31:0] ref_logical(input logic [31:0] a, input logic [31:0] b,
                                                input logic [1:0] op);
        if (b > 32'd31) return 32'h0;
        return (op == OP_SLL) ? (a << b[4:0]) : (a >> b[4:0]);
    endfunction

    task automatic drive(input logic port, input logic v, input logic [31:0] a,
                         input logic [31:0] b, input logic [1:0] op);
        pa[port] = a; pb[port] = b; pop[port] = op;
        if (port) begin
            bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    // Wait (bounded) for this port's ready, record the expected response, step past the edge.
    task automatic grant_wait(input logic port, input logic [31:0] exp, input bit push);
        int   waits;
        logic got;
        waits = 0;
        got   = 1'b0;
        while (!got && waits < 8) begin
            @(negedge clk);
            waits++;
            got = port ? bus.req1_ready : bus.req0_ready;
        end
        check($sformatf("grant_p%0d", port), 32'(got), 32'd1);
        check($sformatf("grant_excl_p%0d", port), 32'(port ? bus.req0_ready : bus.req1_ready), 32'd0);
        if (got && push) sb.push_back('{port, exp, cyc + 2});
        @(posedge clk); #1;
    endtask

    task automatic send(input logic port, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] op, input logic [31:0] exp, input bit push);
        drive(port, 1'b1, a, b, op);
        grant_wait(port, exp, push);
        drive(port, 1'b0, a, b, op);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("drain", 32'(sb.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, OP_SLL);
        drive(1'b1, 1'b0, 32'h0, 32'h0, OP_SLL);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // Response monitor: every pulse must match the oldest scoreboard entry, on time.
    always @(negedge clk) begin
        if (rst === 1'b1 && (bus.rsp0_valid === 1'b1 || bus.rsp1_valid === 1'b1)) begin
            check("rsp_onehot", 32'(bus.rsp0_valid & bus.rsp1_valid), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_rsp", 32'(sb.size()), 32'd1);
            end else begin
                mon_e = sb.pop_front();
                check("rsp_port", 32'(bus.rsp1_valid), 32'(mon_e.port));
                check("rsp_data", bus.rsp_data, mon_e.data);
                check("rsp_cycle", 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic e;
        int   waits;
        logic got;

        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h0, OP_SLL);
        drive(1'b1, 1'b0, 32'h0, 32'h0, OP_SLL);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rsp0", 32'(bus.rsp0_valid), 32'd0);
        check("rst_rsp1", 32'(bus.rsp1_valid), 32'd0);
        check("rst_data", bus.rsp_data, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;

        // Basic SLL on port 0 with busy profile.
        send(1'b0, 32'h0000_00F0, 32'd4, OP_SLL, 32'h0000_0F00, 1'b1);
        @(negedge clk);
        check("busy_n0", 32'(bus.busy), 32'd1);
        @(negedge clk);
        check("busy_n1", 32'(bus.busy), 32'd1);
        check("rsp1_quiet", 32'(bus.rsp1_valid), 32'd0);
        @(negedge clk);
        check("busy_n2", 32'(bus.busy), 32'd0);
        check("rsp0_pulse_end", 32'(bus.rsp0_valid), 32'd0);
        drain();

        // Tie: port 0 first after reset, then strict alternation at full rate.
        do_reset();
        drive(1'b0, 1'b1, 32'hA5A5_0000, 32'd1, OP_SRL);
        drive(1'b1, 1'b1, 32'h0000_5A5A, 32'd2, OP_SLL);
        e = 1'b0;
        for (int g = 0; g < 6; g++) begin
            waits = 0;
            got   = 1'b0;
            while (!got && waits < 4) begin
                @(negedge clk);
                waits++;
                got = bus.req0_ready | bus.req1_ready;
            end
            check($sformatf("rr_grant%0d", g), {30'b0, bus.req1_ready, bus.req0_ready},
                  e ? 32'd2 : 32'd1);
            check($sformatf("rr_spacing%0d", g), 32'(waits), (g == 0) ? 32'd1 : 32'd2);
            if (got) sb.push_back('{e, ref_logical(pa[e], pb[e], pop[e]), cyc + 2});
            @(posedge clk); #1;
            drive(e, 1'b1, pa[e] + 32'h0001_0101, pb[e] + 32'd3, pop[e]);
            e = ~e;
        end
        drive(1'b0, 1'b0, 32'h0, 32'h0, OP_SLL);
        drive(1'b1, 1'b0, 32'h0, 32'h0, OP_SLL);
        drain();

        // Out-of-range and sign-fill cases.
        send(1'b1, 32'h8000_0000, 32'd40, OP_SRA, EXP_SRA_B40, 1'b1);
        send(1'b1, 32'h8000_0000, 32'd40, OP_SLL, 32'h0, 1'b1);
        send(1'b1, 32'h8000_0000, 32'd40, OP_SRL, 32'h0, 1'b1);
        send(1'b0, 32'h8000_0000, 32'd4,  OP_SRA, EXP_SRA_B4, 1'b1);
        send(1'b0, 32'h0000_0001, 32'd32, OP_SLL, 32'h0, 1'b1);
        send(1'b1, 32'h0000_0001, 32'd31, OP_SLL, 32'h8000_0000, 1'b1);
        send(1'b0, 32'h0000_0001, 32'h8000_0000, OP_SLL, 32'h0, 1'b1);

        // Zero amount and pass-through.
        send(1'b0, 32'h1234_5678, 32'd0,  OP_SLL,  32'h1234_5678, 1'b1);
        send(1'b1, 32'h1234_5678, 32'd0,  OP_SRL,  32'h1234_5678, 1'b1);
        send(1'b0, 32'h1234_5678, 32'd0,  OP_SRA,  32'h1234_5678, 1'b1);
        send(1'b1, 32'h1234_5678, 32'd17, OP_PASS, 32'h1234_5678, 1'b1);
        drain();

        // Reset during EXEC discards the operation.
        send(1'b0, 32'h0000_0055, 32'd3, OP_SLL, 32'h0, 1'b0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_rsp", {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        check("midrst_data", bus.rsp_data, 32'h0);
        @(posedge clk); #1 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("postrst_quiet%0d", i), {30'b0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        end
        @(posedge clk); #1;
        send(1'b0, 32'h0000_0003, 32'd2, OP_SLL, 32'h0000_000C, 1'b1);
        drain();

        // Port 0 cancels while port 1 holds; port 0 would have won the tie.
        send(1'b1, 32'h0000_0007, 32'd1, OP_SLL, 32'h0000_000E, 1'b1);
        drive(1'b0, 1'b1, 32'h0000_DEAD, 32'd0, OP_PASS);
        drive(1'b1, 1'b1, 32'h0000_0100, 32'd8, OP_SRL);
        @(negedge clk);
        check("exec_ready", {30'b0, bus.req1_ready, bus.req0_ready}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 32'h0000_DEAD, 32'd0, OP_PASS);
        grant_wait(1'b1, 32'h0000_0001, 1'b1);
        drive(1'b1, 1'b0, 32'h0000_0100, 32'd8, OP_SRL);
        drain();
        repeat (3) @(posedge clk);
        check("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
